pan_ratio_divider: RTL and testbench
====================================

# pan_ratio_divider

Sequential fixed-point divider that consumes the `pan_dividend` / `pan_divisor` / `x_greater_than_y` outputs of `calc_setup` and produces the pan ratio quotient used by the downstream angle lookup and DMX channel mapping. It computes floor(pan_dividend × 2^FRAC_BITS / pan_divisor) by restoring shift-subtract, one quotient bit per clock. It uses a start/busy/done handshake and flags divide-by-zero.

## Interface

Parameters:
- `FRAC_BITS`, default 8: number of fractional quotient bits.
- `QW`, default 11+FRAC_BITS: quotient width; derived, not overridden.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a division; sampled only in IDLE.
- `pan_dividend`, input, 11: unsigned dividend; sampled with `start`.
- `pan_divisor`, input, 11: unsigned divisor; sampled with `start`.
- `x_greater_than_y`, input, 1: octant flag from `calc_setup`; sampled with `start`.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse; the result is valid from this cycle on.
- `quotient`, output, QW: unsigned result, integer part in bits [QW-1:FRAC_BITS].
- `div_zero`, output, 1: high with the result when the divisor was 0.
- `swap_out`, output, 1: `x_greater_than_y` latched at `start`, aligned with `quotient`.

## Operation

- States are IDLE and DIVIDE.
- IDLE with `start`=1 and divisor≠0:
  - Latch the divisor.
  - Load the shift register with {dividend, FRAC_BITS zeros}.
  - Clear the 12-bit partial remainder and the iteration counter.
  - Latch `x_greater_than_y`, clear `div_zero`, and go to DIVIDE.
- IDLE with `start`=1 and divisor=0:
  - Stay in IDLE.
  - At the same edge, set `quotient` to all ones, `div_zero`=1, `swap_out` to the latched flag, and pulse `done`.
- DIVIDE, each cycle:
  - rem' = {rem[10:0], shift MSB}.
  - If rem' ≥ divisor: rem = rem' − divisor and the quotient bit is 1; otherwise rem = rem' and the bit is 0.
  - Shift the quotient bit into the working quotient LSB and increment the counter.
- After QW iterations:
  - Copy the working quotient to `quotient`.
  - Pulse `done`, drop `busy`, and return to IDLE.
- `quotient`, `div_zero` and `swap_out` hold their values until the next accepted `start`.
- `start` while in DIVIDE is ignored and not queued.
- `start` in the cycle in which `done` is high is accepted; back-to-back operation is allowed.
- Input changes outside the sampling edge have no effect.
- A remainder width of 12 bits is sufficient because the divisor is less than 2^11.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `div_zero`=0, `swap_out`=0, counter=0, remainder=0.
- `reset` overrides everything, including mid-division. The result in progress is discarded and `done` is not pulsed.
- Let N = QW (19 at default). `start` sampled in cycle 0:
  - `busy` is high in cycles 1..N.
  - `done` is high in cycle N+1, with `busy` low.
  - `quotient` is valid from cycle N+1.
- Divide-by-zero: `done` and `div_zero` are high in cycle 1, and `busy` never rises.
- Throughput: one result every N+1 cycles.
- Registered outputs only; no combinational input-to-output path.

## Structure

- Shared package `tracking_pkg`:
  - `DIFF_W_X`=11 and `DIVISOR_W`=11, shared with `calc_setup`.
  - `PAN_FRAC_BITS`=8.
  - State encoding constants `DIV_IDLE`, `DIV_RUN`.
- Sub-module `pan_div_step`: combinational single restoring step.
  - Inputs: remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Keeps the FSM and datapath separable and unit-testable.
- Counter width: $clog2(QW+1).

## Test plan

- **Basic ratio:** dividend=200, divisor=100, `x_greater_than_y`=1 → `quotient`=0x00200 (2.0), `div_zero`=0, `swap_out`=1, `done` exactly in cycle 20.
- **Fraction and truncation:**
  - 100/200 → 0x00080 (0.5).
  - 1/3 → 0x00055 (85, truncated).
  - 2047/1 → 0x7FF00.
  - Check each against a floor(a·256/b) reference model across 1000 random pairs.
- **Divide-by-zero:** 400/0 → `quotient`=0x7FFFF, `div_zero`=1, `done` in cycle 1, `busy` never high. A following 400/200 clears `div_zero` and returns 0x00200.
- **Ignored start:** `start` with 300/7 in cycle 5 of a 200/100 run → result is still 0x00200 and no extra `done` pulse.
- **Back-to-back:** second `start` (500/600) in the `done` cycle of the first → second `done` 20 cycles later, `quotient`=0x000D5 (213).
- **Mid-operation reset:** `reset` in cycle 10 of a division → all outputs 0 next cycle, no `done`, and a fresh `start` afterwards works.

Source files
------------

// File: rtl/tracking_pkg.sv
// Shared widths and encodings for the tracking datapath (calc_setup, pan_ratio_divider).
package tracking_pkg;

   // Width of the pan difference produced by calc_setup.
   localparam int unsigned DIFF_W_X      = 11;
   // Width of the divisor produced by calc_setup.
   localparam int unsigned DIVISOR_W     = 11;
   // Fractional bits of the pan ratio quotient.
   localparam int unsigned PAN_FRAC_BITS = 8;
   // One extra bit so a shifted-in remainder never overflows.
   localparam int unsigned REM_W         = DIVISOR_W + 1;

   // Divider FSM encoding.
   localparam logic [0:0] DIV_IDLE = 1'b0;
   localparam logic [0:0] DIV_RUN  = 1'b1;

endpackage

// File: rtl/pan_div_step.sv
// One restoring shift-subtract step: shifts a bit into the remainder and
// subtracts the divisor when it fits.
module pan_div_step
   import tracking_pkg::*;
(
   input  logic [REM_W-1:0]     rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [REM_W-1:0]     rem_out,
   output logic                 q_bit
);

   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] div_ext;

   // Shift, compare and conditionally subtract.
   always_comb begin
      // The remainder is always below the divisor, so its MSB is never lost.
      rem_sh  = {rem_in[REM_W-2:0], bit_in};
      div_ext = {1'b0, divisor};
      if (rem_sh >= div_ext) begin
         rem_out = rem_sh - div_ext;
         q_bit   = 1'b1;
      end else begin
         rem_out = rem_sh;
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/pan_ratio_divider.sv
// Sequential restoring divider: quotient = floor(pan_dividend * 2^FRAC_BITS / pan_divisor),
// one quotient bit per clock, with start/busy/done handshake and divide-by-zero flag.
module pan_ratio_divider
   import tracking_pkg::*;
#(
   parameter  int unsigned FRAC_BITS = PAN_FRAC_BITS,
   localparam int unsigned QW        = DIFF_W_X + FRAC_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DIFF_W_X-1:0]  pan_dividend,
   input  logic [DIVISOR_W-1:0] pan_divisor,
   input  logic                 x_greater_than_y,
   output logic                 busy,
   output logic                 done,
   output logic [QW-1:0]        quotient,
   output logic                 div_zero,
   output logic                 swap_out
);

   localparam int unsigned CNT_W = $clog2(QW + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QW - 1);

   logic [0:0]           state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [QW-1:0]        quotient_q, quotient_d;
   logic                 div_zero_q, div_zero_d;
   logic                 swap_q, swap_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic [QW-1:0]        shift_q, shift_d;
   logic [QW-1:0]        work_q, work_d;
   logic [DIVISOR_W-1:0] divisor_q, divisor_d;

   logic [REM_W-1:0]     step_rem;
   logic                 step_bit;
   logic [QW-1:0]        work_next;

   pan_div_step u_step (
      .rem_in  (rem_q),
      .bit_in  (shift_q[QW-1]),
      .divisor (divisor_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign work_next = {work_q[QW-2:0], step_bit};

   // Next-state logic for the handshake FSM and datapath.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      quotient_d = quotient_q;
      div_zero_d = div_zero_q;
      swap_d     = swap_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      shift_d    = shift_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               swap_d = x_greater_than_y;
               if (pan_divisor == '0) begin
                  // Saturate and report immediately; no iteration needed.
                  quotient_d = '1;
                  div_zero_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  divisor_d  = pan_divisor;
                  shift_d    = {pan_dividend, {FRAC_BITS{1'b0}}};
                  rem_d      = '0;
                  cnt_d      = '0;
                  work_d     = '0;
                  div_zero_d = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            rem_d   = step_rem;
            shift_d = {shift_q[QW-2:0], 1'b0};
            work_d  = work_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               quotient_d = work_next;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = DIV_IDLE;
            end
         end
         default: begin
            state_d = DIV_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DIV_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quotient_q <= '0;
         div_zero_q <= 1'b0;
         swap_q     <= 1'b0;
         cnt_q      <= '0;
         rem_q      <= '0;
         shift_q    <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quotient_q <= quotient_d;
         div_zero_q <= div_zero_d;
         swap_q     <= swap_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         shift_q    <= shift_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quotient_q;
   assign div_zero = div_zero_q;
   assign swap_out = swap_q;

endmodule

// File: tb/tb_pan_ratio_divider.sv
// Directed self-checking bench for pan_ratio_divider.
module tb_pan_ratio_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] pan_dividend;
   logic [10:0] pan_divisor;
   logic        x_greater_than_y;
   logic        busy;
   logic        done;
   logic [18:0] quotient;
   logic        div_zero;
   logic        swap_out;

   int n_checks = 0;
   int n_pass   = 0;

   pan_ratio_divider dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .pan_dividend     (pan_dividend),
      .pan_divisor      (pan_divisor),
      .x_greater_than_y (x_greater_than_y),
      .busy             (busy),
      .done             (done),
      .quotient         (quotient),
      .div_zero         (div_zero),
      .swap_out         (swap_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one start and wait for done; lat is the cycle done is seen (start edge = 0).
   task automatic do_div(input logic [10:0] a, input logic [10:0] b, input logic x,
                         output int lat, output int busy_cnt);
      pan_dividend     = a;
      pan_divisor      = b;
      x_greater_than_y = x;
      start            = 1'b1;
      tick();
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
   endtask

   // Directed vectors: dividend, divisor, flag, expected quotient, expected div_zero.
   localparam int NV = 8;
   logic [10:0] va [NV] = '{11'd200, 11'd100, 11'd1, 11'd2047, 11'd400, 11'd400, 11'd0, 11'd2047};
   logic [10:0] vb [NV] = '{11'd100, 11'd200, 11'd3, 11'd1,    11'd0,   11'd200, 11'd5, 11'd2047};
   logic        vx [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [18:0] vq [NV] = '{19'h00200, 19'h00080, 19'h00055, 19'h7FF00,
                            19'h7FFFF, 19'h00200, 19'h00000, 19'h00100};
   logic        vz [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      int lat;
      int bcnt;
      int dones;
      int seen;
      int unsigned ra;
      int unsigned rb;
      int unsigned rq;

      reset            = 1'b1;
      start            = 1'b0;
      pan_dividend     = '0;
      pan_divisor      = '0;
      x_greater_than_y = 1'b0;
      tick();
      tick();
      check("reset_busy",     busy,     0);
      check("reset_done",     done,     0);
      check("reset_quotient", quotient, 0);
      check("reset_div_zero", div_zero, 0);
      check("reset_swap",     swap_out, 0);
      reset = 1'b0;
      tick();

      // Directed vectors, including divide-by-zero followed by a normal divide.
      for (int i = 0; i < NV; i++) begin
         do_div(va[i], vb[i], vx[i], lat, bcnt);
         check($sformatf("v%0d_latency", i),  lat,      vz[i] ? 1 : 20);
         check($sformatf("v%0d_busy_cyc", i), bcnt,     vz[i] ? 0 : 19);
         check($sformatf("v%0d_quotient", i), quotient, vq[i]);
         check($sformatf("v%0d_div_zero", i), div_zero, vz[i]);
         check($sformatf("v%0d_swap", i),     swap_out, vx[i]);
         tick();
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_hold_q", i), quotient, vq[i]);
      end

      // Start during DIVIDE must be ignored.
      pan_dividend = 11'd200; pan_divisor = 11'd100; x_greater_than_y = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      seen  = 0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 5) begin
            pan_dividend = 11'd300; pan_divisor = 11'd7; x_greater_than_y = 1'b0; start = 1'b1;
         end
         if (done === 1'b1) begin
            dones++;
            seen = c;
         end
         tick();
         start = 1'b0;
      end
      check("ign_done_count", dones,    1);
      check("ign_done_cycle", seen,     20);
      check("ign_quotient",   quotient, 19'h00200);
      check("ign_swap",       swap_out, 1);

      // Back-to-back: second start in the done cycle of the first.
      do_div(11'd200, 11'd100, 1'b0, lat, bcnt);
      check("b2b_first_lat", lat,      20);
      check("b2b_first_q",   quotient, 19'h00200);
      do_div(11'd500, 11'd600, 1'b1, lat, bcnt);
      check("b2b_second_lat", lat,      20);
      check("b2b_second_q",   quotient, 19'h000D5);
      check("b2b_second_sw",  swap_out, 1);
      tick();

      // Reset in cycle 10 of a division.
      pan_dividend = 11'd700; pan_divisor = 11'd3; x_greater_than_y = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", busy,     0);
      check("rst_mid_done", done,     0);
      check("rst_mid_q",    quotient, 0);
      check("rst_mid_dz",   div_zero, 0);
      check("rst_mid_sw",   swap_out, 0);
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         if (done === 1'b1) dones++;
         tick();
      end
      check("rst_no_done", dones, 0);
      do_div(11'd100, 11'd200, 1'b1, lat, bcnt);
      check("rst_fresh_lat", lat,      20);
      check("rst_fresh_q",   quotient, 19'h00080);
      tick();

      // Random pairs against floor(a*256/b).
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom_range(0, 2047);
         rb = $urandom_range(1, 2047);
         rq = (ra * 256) / rb;
         do_div(ra[10:0], rb[10:0], 1'b0, lat, bcnt);
         check($sformatf("rnd_%0d_%0d", ra, rb), quotient, rq);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
